// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: FSM states and bus widths.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int WORD_W     = 32;
  localparam int BE_W       = 4;
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/data_mem_ram.sv
// Word-organised data storage with a byte-enable synchronous write port and a
// synchronous read port. The read register doubles as the responder's rdata
// output, so it can be cleared (error response) and is reset to zero, while
// the storage array itself is never reset.
module data_mem_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [AW-1:0]     addr,
  input  logic [BE_W-1:0]   be,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-lane write: only lanes whose enable bit is set are updated.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register: cleared on error, loaded on a good read, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_clr) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's data bus: captures one load/store under
// req/ack, waits WAIT_CYC cycles, performs the access (or rejects an illegal
// address) and returns a one-cycle ack with err and rdata.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYC - 1);

  state_t                state, next_state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  cap_we;
  logic [31:0]           cap_addr;
  logic [WORD_W-1:0]     cap_wdata;
  logic [BE_W-1:0]       cap_be;
  logic                  addr_err;
  logic                  ram_wr, ram_rd, ram_clr;

  // Next-state decode and the access-cycle RAM controls.
  always_comb begin
    next_state = state;
    addr_err   = (cap_addr[1:0] != 2'b00) ||
                 ({2'b00, cap_addr[31:2]} >= WORD_W'(DEPTH));
    ram_wr     = 1'b0;
    ram_rd     = 1'b0;
    ram_clr    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = (WAIT_CYC == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        next_state = RESP;
        ram_wr     = cap_we && !addr_err;
        ram_rd     = !cap_we && !addr_err;
        ram_clr    = addr_err;
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Wait counter and request capture; later bus changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_be    <= '0;
    end else begin
      if (state == IDLE) begin
        cnt <= WAIT_LOAD;
        if (req) begin
          cap_we    <= we;
          cap_addr  <= addr;
          cap_wdata <= wdata;
          cap_be    <= be;
        end
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Registered handshake outputs derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack  <= 1'b0;
      err  <= 1'b0;
      busy <= 1'b0;
    end else begin
      ack  <= (next_state == RESP);
      err  <= (state == ACCESS) && addr_err;
      busy <= (next_state != IDLE);
    end
  end

  data_mem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (ram_wr),
    .rd_en  (ram_rd),
    .rd_clr (ram_clr),
    .addr   (cap_addr[AW+1:2]),
    .be     (cap_be),
    .wdata  (cap_wdata),
    .rdata  (rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (WAIT_CYC=2 and WAIT_CYC=0) driven by
// directed and random transactions, compared against a word-array model.
module tb_data_mem_responder;

   localparam int DEPTH = 64;
   localparam int WC [2] = '{2, 0};

   logic        clk = 1'b0;
   logic [1:0]  rst_n;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic [3:0]  be    [2];
   logic [1:0]  ack;
   logic [1:0]  err;
   logic [1:0]  busy;
   logic [31:0] rdata [2];

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m   [2][DEPTH];
   logic [31:0] last_rd [2];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYC(2)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .wdata(wdata[0]), .be(be[0]), .ack(ack[0]), .err(err[0]),
      .rdata(rdata[0]), .busy(busy[0])
   );

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYC(0)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .wdata(wdata[1]), .be(be[1]), .ack(ack[1]), .err(err[1]),
      .rdata(rdata[1]), .busy(busy[1])
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drives one request starting just after a negedge with the DUT idle; holds
   // req until ack, optionally scrambles the bus while busy, then waits out the
   // mandatory idle cycle. lat is the ack cycle count after acceptance.
   task automatic applyStimulus(input int d, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] b, input bit scr,
                                output int lat, output logic e, output logic [31:0] rd);
      bit seen;
      we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b; req[d] = 1'b1;
      @(posedge clk);
      lat = 0; e = 1'bx; rd = 'x; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (i == 0) checkOutput("busy_rise", 32'(busy[d]), 32'd1);
         if (ack[d]) begin
            seen = 1; e = err[d]; rd = rdata[d];
         end else if (scr) begin
            we[d] = 1'($urandom); addr[d] = $urandom; wdata[d] = $urandom; be[d] = 4'($urandom);
         end
      end
      req[d] = 1'b0;
      if (!seen) lat = -1;
      @(negedge clk);
      checkOutput("busy_fall", 32'(busy[d]), 32'd0);
      checkOutput("ack_drop", 32'(ack[d]), 32'd0);
      checkOutput("err_drop", 32'(err[d]), 32'd0);
   endtask

   // Reference behaviour of one access from the address/lane rules.
   task automatic modelAccess(input int d, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] b,
                              output logic e, output logic [31:0] rd);
      int unsigned idx;
      idx = a / 4;
      e = (a % 4 != 0) || (idx >= DEPTH);
      if (e) rd = 32'h0;
      else if (!w) rd = mem_m[d][idx];
      else begin
         for (int i = 0; i < 4; i++)
            if (b[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
         rd = last_rd[d];
      end
      last_rd[d] = rd;
   endtask

   // One complete transaction checked against the model.
   task automatic runTxn(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] b, input bit scr,
                         output logic [31:0] rd_o);
      logic ee, oe;
      logic [31:0] er;
      int lat;
      modelAccess(d, w, a, wd, b, ee, er);
      applyStimulus(d, w, a, wd, b, scr, lat, oe, rd_o);
      checkOutput("latency", 32'(lat), 32'(WC[d] + 2));
      checkOutput("err", 32'(oe), 32'(ee));
      checkOutput("rdata", rd_o, er);
   endtask

   initial begin
      logic [31:0] r, r1, r2, e1, e2, a;
      int n, n1, n2, sel;

      rst_n = 2'b00; req = 2'b00; we = 2'b00;
      for (int d = 0; d < 2; d++) begin
         addr[d] = '0; wdata[d] = '0; be[d] = '0; last_rd[d] = '0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checkOutput("rst_ack", 32'(ack[d]), 32'd0);
         checkOutput("rst_err", 32'(err[d]), 32'd0);
         checkOutput("rst_busy", 32'(busy[d]), 32'd0);
         checkOutput("rst_rdata", rdata[d], 32'd0);
      end
      rst_n = 2'b11;
      @(negedge clk);

      // Give every word a known value so later loads are predictable.
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < DEPTH; i++)
            runTxn(d, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, r);

      // Basic store then load, WAIT_CYC=2.
      runTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, r);
      runTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, r);
      checkOutput("basic_load", r, 32'hDEADBEEF);

      // Byte-lane partial write.
      runTxn(0, 1'b1, 32'h8, 32'h11223344, 4'hF, 1'b0, r);
      runTxn(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 1'b0, r);
      runTxn(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, r);
      checkOutput("partial_load", r, 32'h11BB33DD);

      // Store with no lanes enabled leaves the word alone.
      runTxn(0, 1'b1, 32'h8, 32'h55555555, 4'b0000, 1'b0, r);
      runTxn(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b0, r);
      checkOutput("be0_load", r, 32'h11BB33DD);

      // Error paths.
      runTxn(0, 1'b0, 32'h6, 32'h0, 4'h0, 1'b0, r);
      checkOutput("misaligned_rdata", r, 32'h0);
      runTxn(0, 1'b1, 32'(4 * DEPTH), 32'h12345678, 4'hF, 1'b0, r);
      runTxn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, r);

      // Back-to-back on WAIT_CYC=0 with the address changed after the first ack.
      e1 = mem_m[1][4]; e2 = mem_m[1][3];
      n = 0; n1 = -1; n2 = -1; r1 = '0; r2 = '0;
      we[1] = 1'b0; addr[1] = 32'h10; be[1] = 4'hF; req[1] = 1'b1;
      for (int i = 0; i < 30 && n2 < 0; i++) begin
         @(negedge clk);
         n++;
         if (ack[1]) begin
            if (n1 < 0) begin
               n1 = n; r1 = rdata[1]; addr[1] = 32'hC;
            end else begin
               n2 = n; r2 = rdata[1]; req[1] = 1'b0;
            end
         end
      end
      req[1] = 1'b0;
      @(negedge clk);
      last_rd[1] = e2;
      checkOutput("b2b_first_lat", 32'(n1), 32'd2);
      checkOutput("b2b_spacing", 32'(n2 - n1), 32'd3);
      checkOutput("b2b_rdata1", r1, e1);
      checkOutput("b2b_rdata2", r2, e2);

      // Address changed while busy: result follows the captured address.
      runTxn(1, 1'b1, 32'h8, 32'hA5A5F00F, 4'hF, 1'b1, r);
      runTxn(1, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, r);
      checkOutput("inflight_load", r, 32'hA5A5F00F);

      // Randomised traffic on both responders.
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 8) a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (sel == 8) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else a = $urandom | 32'(4 * DEPTH);
            runTxn(d, 1'($urandom), a, $urandom, 4'($urandom), 1'b1, r);
         end
      end

      // Reset during the wait of a store: nothing is written.
      runTxn(0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0, r);
      runTxn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, r);
      runTxn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, r);
      we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF; req[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("pre_reset_busy", 32'(busy[0]), 32'd1);
      rst_n[0] = 1'b0;
      #1;
      checkOutput("mid_rst_ack", 32'(ack[0]), 32'd0);
      checkOutput("mid_rst_err", 32'(err[0]), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy[0]), 32'd0);
      checkOutput("mid_rst_rdata", rdata[0], 32'd0);
      req[0] = 1'b0;
      @(negedge clk);
      rst_n[0] = 1'b1;
      last_rd[0] = 32'h0;
      @(negedge clk);
      runTxn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, r);
      checkOutput("post_reset_load", r, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
